// File: rtl/mdu_issue_buffer.sv
// In-order issue buffer between the integer issue stage and the RV64M MDU; one op in flight.
// Optional build macro MDU_ZERO_FASTPATH_EN: zero-operand multiplies complete without the MDU.
module mdu_issue_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  in_rs1_i,
  input  logic [XLEN-1:0]  in_rs2_i,
  input  logic [2:0]       in_funct3_i,
  input  logic             in_word_i,
  input  logic [4:0]       in_rd_i,
  input  logic [TAG_W-1:0] in_tag_i,
  input  logic             flush_i,
  output logic             mdu_req_valid_o,
  input  logic             mdu_req_ready_i,
  output logic [XLEN-1:0]  mdu_rs1_o,
  output logic [XLEN-1:0]  mdu_rs2_o,
  output logic [2:0]       mdu_funct3_o,
  output logic             mdu_word_o,
  input  logic             mdu_resp_valid_i,
  input  logic [XLEN-1:0]  mdu_result_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [XLEN-1:0]  wb_data_o,
  output logic [4:0]       wb_rd_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0]  rs1_q [DEPTH];
  logic [XLEN-1:0]  rs2_q [DEPTH];
  logic [2:0]       f3_q  [DEPTH];
  logic             word_q[DEPTH];
  logic [4:0]       rd_q  [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             inflight_q, inflight_d;
  logic             squash_q, squash_d;
  logic [4:0]       inf_rd_q, inf_rd_d;
  logic [TAG_W-1:0] inf_tag_q, inf_tag_d;
  logic             wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;

  logic [XLEN-1:0]  head_rs1, head_rs2;
  logic [2:0]       head_f3;
  logic             head_word;
  logic             issue_ok, fast_hit, req_fire, fast_fire, push, pop, resp;

  assign head_rs1  = rs1_q[rd_ptr_q];
  assign head_rs2  = rs2_q[rd_ptr_q];
  assign head_f3   = f3_q[rd_ptr_q];
  assign head_word = word_q[rd_ptr_q];

`ifdef MDU_ZERO_FASTPATH_EN
  assign fast_hit = ~head_f3[2] &
                    (head_word ? ((~|head_rs1[31:0]) | (~|head_rs2[31:0]))
                               : ((~|head_rs1) | (~|head_rs2)));
`else
  assign fast_hit = 1'b0;
`endif

  assign in_ready_o = (count_q < CW'(DEPTH));
  // The wb slot must be free before issuing, so a returning pulse always has a home.
  assign issue_ok   = (count_q != '0) && !inflight_q && !wb_valid_q && !flush_i;
  assign mdu_req_valid_o = issue_ok && !fast_hit;
  assign req_fire   = mdu_req_valid_o && mdu_req_ready_i;
  assign fast_fire  = issue_ok && fast_hit;
  assign pop        = req_fire || fast_fire;
  assign push       = in_valid_i && in_ready_o && !flush_i;
  assign resp       = mdu_resp_valid_i && inflight_q;

  assign mdu_rs1_o    = head_rs1;
  assign mdu_rs2_o    = head_rs2;
  assign mdu_funct3_o = head_f3;
  assign mdu_word_o   = head_word;

  assign wb_valid_o = wb_valid_q;
  assign wb_data_o  = wb_data_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_tag_o   = wb_tag_q;
  assign busy_o     = (count_q != '0) || inflight_q || wb_valid_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    squash_d   = squash_q;
    inf_rd_d   = inf_rd_q;
    inf_tag_d  = inf_tag_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_tag_d   = wb_tag_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      wb_valid_d = 1'b0;
      // The MDU cannot be aborted: remember to drop its result when it lands.
      if (inflight_q) begin
        if (mdu_resp_valid_i) begin
          inflight_d = 1'b0;
          squash_d   = 1'b0;
        end else begin
          squash_d   = 1'b1;
        end
      end
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (wb_valid_q && wb_ready_i) wb_valid_d = 1'b0;
      if (resp) begin
        inflight_d = 1'b0;
        if (squash_q) begin
          squash_d = 1'b0;
        end else begin
          wb_valid_d = 1'b1;
          wb_data_d  = mdu_result_i;
          wb_rd_d    = inf_rd_q;
          wb_tag_d   = inf_tag_q;
        end
      end
      if (req_fire) begin
        inflight_d = 1'b1;
        inf_rd_d   = rd_q[rd_ptr_q];
        inf_tag_d  = tag_q[rd_ptr_q];
      end
      if (fast_fire) begin
        wb_valid_d = 1'b1;
        wb_data_d  = '0;
        wb_rd_d    = rd_q[rd_ptr_q];
        wb_tag_d   = tag_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
      inf_rd_q   <= '0;
      inf_tag_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_tag_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
      inf_rd_q   <= inf_rd_d;
      inf_tag_q  <= inf_tag_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_tag_q   <= wb_tag_d;
    end
  end

  // Entry storage is reset so the head-driven MDU operand outputs start at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        rs1_q[i]  <= '0;
        rs2_q[i]  <= '0;
        f3_q[i]   <= '0;
        word_q[i] <= 1'b0;
        rd_q[i]   <= '0;
        tag_q[i]  <= '0;
      end
    end else if (push) begin
      rs1_q[wr_ptr_q]  <= in_rs1_i;
      rs2_q[wr_ptr_q]  <= in_rs2_i;
      f3_q[wr_ptr_q]   <= in_funct3_i;
      word_q[wr_ptr_q] <= in_word_i;
      rd_q[wr_ptr_q]   <= in_rd_i;
      tag_q[wr_ptr_q]  <= in_tag_i;
    end
  end

  resp_needs_inflight: assert property (@(posedge clk_i) disable iff (rst_i)
                                        mdu_resp_valid_i |-> inflight_q);

endmodule
